axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read master port (AR/R channels, bursts) between the instruction fetch path (I-cache refill) and the load/store unit.
- Sits between those two requesters and the io_master read channels at the core boundary.
- Locks a grant from address acceptance to the final data beat, alternates grants round-robin under contention, and flags burst-length protocol errors.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
MAX_LEN, 8, width of arlen fields (AXI4 beats-1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
ifu_arvalid / lsu_arvalid  input  1  requester read address valid
ifu_arready / lsu_arready  output  1  address accepted, routed from io_master_arready to the granted requester only
ifu_araddr / lsu_araddr  input  ADDR_W  requester read address
ifu_arlen / lsu_arlen  input  MAX_LEN  requester burst length minus one
ifu_rvalid / lsu_rvalid  output  1  data beat valid to the granted requester only
ifu_rready / lsu_rready  input  1  requester data ready
ifu_rdata / lsu_rdata  output  DATA_W  broadcast io_master_rdata
ifu_rresp / lsu_rresp  output  2  broadcast io_master_rresp
ifu_rlast / lsu_rlast  output  1  last beat, gated to the granted requester
io_master_arvalid  output  1  downstream address valid
io_master_arready  input  1  downstream address ready
io_master_araddr  output  ADDR_W  muxed address
io_master_arlen  output  MAX_LEN  muxed burst length
io_master_arsize  output  3  constant 3'b010
io_master_arburst  output  2  constant 2'b01 (INCR)
io_master_rvalid  input  1  downstream data valid
io_master_rready  output  1  granted requester's rready
io_master_rdata  input  DATA_W  read data
io_master_rresp  input  2  read response
io_master_rlast  input  1  last beat
busy  output  1  state != IDLE
grant_lsu  output  1  current owner (1 = LSU, 0 = IFU); valid when busy
protocol_err  output  1  sticky burst-length mismatch flag

Behaviour:
- Reset (async, active-high): state=IDLE, grant_lsu=0, last_grant=IFU, beat_cnt=0, len_q=0, protocol_err=0.
- All handshake outputs are 0 while in reset and in IDLE: io_master_arvalid, io_master_rready, *_arready, *_rvalid, *_rlast.
- States: IDLE, ADDR, DATA.
- IDLE:
  - No requests: stay in IDLE.
  - One arvalid: grant that requester.
  - Both arvalid: grant the requester opposite to last_grant.
  - Grant registers at the clock edge, then go to ADDR. Minimum AR latency is 1 cycle from request to io_master_arvalid.
- ADDR:
  - io_master_arvalid/araddr/arlen = granted requester's values.
  - granted *_arready = io_master_arready.
  - On io_master_arvalid && io_master_arready: latch len_q=arlen, beat_cnt=0, last_grant=grant, go to DATA.
  - Granted arvalid dropping (illegal) leaves io_master_arvalid=0; stay in ADDR.
- DATA:
  - granted *_rvalid = io_master_rvalid; io_master_rready = granted *_rready; *_rlast gated the same way.
  - Non-granted side sees rvalid=0, rlast=0.
  - Each beat handshake increments beat_cnt (MAX_LEN+1 bits, no wrap).
  - On a beat with rlast=1: go to IDLE. Set protocol_err if beat_cnt != len_q at that beat.
  - beat_cnt reaching len_q with rlast=0 also sets protocol_err. The arbiter still waits for rlast, so the grant is never released mid-burst.
- The non-granted requester's arvalid is held off (arready=0) until the grant returns to IDLE. No preemption.
- Back-to-back: from the last beat to the next io_master_arvalid takes 1 idle cycle.
- protocol_err clears only on reset.

Test Plan:
- Single IFU request, addr 0x3000_0000, arlen=3, arready on 1st cycle, 4 beats with rlast on beat 4 -> ifu_rvalid pulses 4x, lsu sees none, busy drops the cycle after beat 4, protocol_err=0.
- Both request in the same IDLE cycle after reset (last_grant=IFU) -> LSU granted first; IFU granted next. Repeated simultaneous requests alternate LSU, IFU, LSU.
- LSU burst in DATA while IFU raises arvalid -> ifu_arready stays 0 until LSU rlast. IFU io_master_arvalid appears exactly 1 cycle later.
- Granted requester holds rready=0 for 3 cycles mid-burst (io_master_rvalid=1) -> io_master_rready=0, beat not counted, data delivered when rready rises.
- arlen=1 but rlast on beat 1 -> protocol_err=1 and stays set. Also arlen=0 with rlast delayed to beat 2 -> protocol_err=1, IDLE only after the beat-2 rlast.
- Assert reset during DATA -> outputs 0 and state IDLE immediately without a clock edge. The next request is served normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4 read arbiter: the I-fetch refill path and the load/store unit share one
// AR/R master port, with the grant held from address acceptance through the final data beat.
module axi_read_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [MAX_LEN-1:0] ifu_arlen,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [MAX_LEN-1:0] lsu_arlen,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [MAX_LEN-1:0] io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    output logic              busy,
    output logic              grant_lsu,
    output logic              protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [MAX_LEN:0]     beat_cnt_q, beat_cnt_d;
    logic [MAX_LEN-1:0]   len_q, len_d;
    logic                 perr_q, perr_d;

    logic                 sel_arvalid_s;
    logic [ADDR_W-1:0]    sel_araddr_s;
    logic [MAX_LEN-1:0]   sel_arlen_s;
    logic                 sel_rready_s;
    logic                 ar_hs_s;
    logic                 r_hs_s;
    logic                 at_len_s;
    logic                 past_len_s;
    logic                 cnt_full_s;

    // Select the granted requester's address-channel and rready signals.
    always_comb begin
        if (grant_q) begin
            sel_arvalid_s = lsu_arvalid;
            sel_araddr_s  = lsu_araddr;
            sel_arlen_s   = lsu_arlen;
            sel_rready_s  = lsu_rready;
        end else begin
            sel_arvalid_s = ifu_arvalid;
            sel_araddr_s  = ifu_araddr;
            sel_arlen_s   = ifu_arlen;
            sel_rready_s  = ifu_rready;
        end
    end

    assign ar_hs_s    = io_master_arvalid && io_master_arready;
    assign r_hs_s     = io_master_rvalid && io_master_rready;
    assign at_len_s   = (beat_cnt_q == {1'b0, len_q});
    assign past_len_s = (beat_cnt_q >= {1'b0, len_q});
    assign cnt_full_s = (beat_cnt_q == {(MAX_LEN+1){1'b1}});

    // Next-state, grant selection and burst bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        perr_d       = perr_q;
        case (state_q)
            IDLE: begin
                if (ifu_arvalid && lsu_arvalid) begin
                    grant_d = ~last_grant_q;
                    state_d = ADDR;
                end else if (lsu_arvalid) begin
                    grant_d = 1'b1;
                    state_d = ADDR;
                end else if (ifu_arvalid) begin
                    grant_d = 1'b0;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (ar_hs_s) begin
                    len_d        = sel_arlen_s;
                    beat_cnt_d   = {(MAX_LEN+1){1'b0}};
                    last_grant_d = grant_q;
                    state_d      = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (r_hs_s) begin
                    if (io_master_rlast) begin
                        if (!at_len_s) begin
                            perr_d = 1'b1;
                        end else begin
                            perr_d = perr_q;
                        end
                        state_d = IDLE;
                    end else begin
                        // A non-final beat at or beyond arlen is an overrun; keep waiting for rlast.
                        if (past_len_s) begin
                            perr_d = 1'b1;
                        end else begin
                            perr_d = perr_q;
                        end
                        if (!cnt_full_s) begin
                            beat_cnt_d = beat_cnt_q + {{MAX_LEN{1'b0}}, 1'b1};
                        end else begin
                            beat_cnt_d = beat_cnt_q;
                        end
                    end
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            beat_cnt_q   <= {(MAX_LEN+1){1'b0}};
            len_q        <= {MAX_LEN{1'b0}};
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            perr_q       <= perr_d;
        end
    end

    // Handshake routing: only the owner of the grant sees arready, rvalid and rlast.
    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        ifu_arready       = 1'b0;
        lsu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_rvalid        = 1'b0;
        ifu_rlast         = 1'b0;
        lsu_rlast         = 1'b0;
        case (state_q)
            ADDR: begin
                io_master_arvalid = sel_arvalid_s;
                ifu_arready       = ~grant_q & io_master_arready;
                lsu_arready       = grant_q & io_master_arready;
            end
            DATA: begin
                io_master_rready = sel_rready_s;
                ifu_rvalid       = ~grant_q & io_master_rvalid;
                lsu_rvalid       = grant_q & io_master_rvalid;
                ifu_rlast        = ~grant_q & io_master_rlast;
                lsu_rlast        = grant_q & io_master_rlast;
            end
            default: begin
                io_master_arvalid = 1'b0;
            end
        endcase
    end

    assign io_master_araddr  = sel_araddr_s;
    assign io_master_arlen   = sel_arlen_s;
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;

    assign ifu_rdata = io_master_rdata;
    assign lsu_rdata = io_master_rdata;
    assign ifu_rresp = io_master_rresp;
    assign lsu_rresp = io_master_rresp;

    assign busy         = (state_q != IDLE);
    assign grant_lsu    = grant_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed requests push expected AR/R items, and a
// negedge monitor pops and compares them whenever the DUT shows a handshake.
module tb_axi_read_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [1:0]  lsu_rresp;
    logic        io_master_arvalid, io_master_arready;
    logic [31:0] io_master_araddr;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid, io_master_rready, io_master_rlast;
    logic [31:0] io_master_rdata;
    logic [1:0]  io_master_rresp;
    logic        busy, grant_lsu, protocol_err;

    int checks = 0;
    int errs   = 0;

    typedef struct packed {
        logic        side;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic        side;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];
    ar_t mon_ar;
    r_t  mon_r;

    axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(8)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
        .io_master_rlast(io_master_rlast),
        .busy(busy), .grant_lsu(grant_lsu), .protocol_err(protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic req(input logic side, input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.side = side;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
        if (side) begin
            lsu_araddr = addr; lsu_arlen = len; lsu_arvalid = 1'b1;
        end else begin
            ifu_araddr = addr; ifu_arlen = len; ifu_arvalid = 1'b1;
        end
    endtask

    task automatic wait_ar(input logic side);
        int n;
        n = 0;
        while (!(io_master_arvalid && io_master_arready && (side ? lsu_arready : ifu_arready))) begin
            @(negedge clock);
            n++;
            if (n > 40) begin
                checks++;
                errs++;
                $display("FAIL ar_timeout: side %0d never got arready", side);
                return;
            end
        end
        @(posedge clock);
        #1;
        if (side) lsu_arvalid = 1'b0;
        else      ifu_arvalid = 1'b0;
    endtask

    task automatic send_beats(input logic side, input int n, input int lastpos,
                              input logic [31:0] base, input int stall_beat);
        r_t e;
        int k;
        for (int i = 0; i < n; i++) begin
            io_master_rvalid = 1'b1;
            io_master_rdata  = base + 32'(i);
            io_master_rresp  = 2'(i);
            io_master_rlast  = (i == lastpos);
            e.side = side;
            e.data = io_master_rdata;
            e.resp = io_master_rresp;
            e.last = io_master_rlast;
            exp_r.push_back(e);
            if (i == stall_beat) begin
                if (side) lsu_rready = 1'b0;
                else      ifu_rready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_rready", 64'(io_master_rready), 64'd0);
                end
                @(posedge clock);
                #1;
                if (side) lsu_rready = 1'b1;
                else      ifu_rready = 1'b1;
            end
            k = 0;
            do begin
                @(negedge clock);
                chk("ar_hold_off", 64'({io_master_arvalid, ifu_arready, lsu_arready}), 64'd0);
                k++;
            end while (!(io_master_rvalid && io_master_rready) && k < 40);
            if (k >= 40) begin
                checks++;
                errs++;
                $display("FAIL beat_timeout: beat %0d of side %0d not accepted", i, side);
            end
            @(posedge clock);
            #1;
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
    endtask

    // Monitor: every AR handshake and every requester-side beat must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset) begin
            if (io_master_arvalid && io_master_arready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL ar_unexpected: addr 0x%0h issued with none expected", io_master_araddr);
                end else begin
                    mon_ar = exp_ar.pop_front();
                    chk("ar_grant", 64'({lsu_arready, ifu_arready, io_master_araddr, io_master_arlen}),
                        64'({mon_ar.side, ~mon_ar.side, mon_ar.addr, mon_ar.len}));
                end
            end
            if (ifu_rvalid && ifu_rready) begin
                if (exp_r.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL r_unexpected: ifu beat 0x%0h with none expected", ifu_rdata);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("r_beat_ifu", 64'({1'b0, ifu_rdata, ifu_rresp, ifu_rlast}), 64'(mon_r));
                end
            end
            if (lsu_rvalid && lsu_rready) begin
                if (exp_r.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL r_unexpected: lsu beat 0x%0h with none expected", lsu_rdata);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("r_beat_lsu", 64'({1'b1, lsu_rdata, lsu_rresp, lsu_rlast}), 64'(mon_r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifu_araddr = 32'd0; ifu_arlen = 8'd0; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = 32'd0; lsu_arlen = 8'd0; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        io_master_arready = 1'b1; io_master_rvalid = 1'b1; io_master_rlast = 1'b1;
        io_master_rdata = 32'd0; io_master_rresp = 2'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_handshake", 64'({io_master_arvalid, io_master_rready, ifu_arready, lsu_arready,
                                  ifu_rvalid, lsu_rvalid, ifu_rlast, lsu_rlast}), 64'd0);
        chk("rst_status", 64'({busy, grant_lsu, protocol_err}), 64'd0);
        chk("ar_constants", 64'({io_master_arsize, io_master_arburst}), 64'({3'b010, 2'b01}));
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single IFU burst of 4 beats.
        req(1'b0, 32'h3000_0000, 8'd3);
        wait_ar(1'b0);
        send_beats(1'b0, 4, 3, 32'hA000_0000, -1);
        @(negedge clock);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        chk("t1_perr", 64'(protocol_err), 64'd0);
        @(posedge clock);
        #1;

        // Simultaneous requests alternate LSU, IFU, LSU, IFU.
        for (int r = 0; r < 2; r++) begin
            req(1'b1, 32'h4000_0100 + 32'(r * 16), 8'd1);
            req(1'b0, 32'h3000_0040 + 32'(r * 16), 8'd0);
            wait_ar(1'b1);
            send_beats(1'b1, 2, 1, 32'hB000_0000 + 32'(r * 256), -1);
            wait_ar(1'b0);
            send_beats(1'b0, 1, 0, 32'hC000_0000 + 32'(r * 256), -1);
        end

        // IFU held off during an LSU burst, then issued after one idle cycle.
        req(1'b1, 32'h5000_0000, 8'd2);
        wait_ar(1'b1);
        ifu_araddr = 32'h3000_0800; ifu_arlen = 8'd1; ifu_arvalid = 1'b1;
        send_beats(1'b1, 3, 2, 32'hD000_0000, -1);
        exp_ar.push_back(ar_t'({1'b0, 32'h3000_0800, 8'd1}));
        @(negedge clock);
        chk("t3_idle_gap", 64'(io_master_arvalid), 64'd0);
        @(negedge clock);
        chk("t3_ar_next", 64'(io_master_arvalid), 64'd1);
        wait_ar(1'b0);
        send_beats(1'b0, 2, 1, 32'hD100_0000, -1);

        // Mid-burst rready stall: beat not consumed until rready returns.
        req(1'b0, 32'h3000_1000, 8'd3);
        wait_ar(1'b0);
        send_beats(1'b0, 4, 3, 32'hE000_0000, 1);
        @(negedge clock);
        chk("t4_perr", 64'(protocol_err), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;

        // arlen=0 but rlast only on beat 2.
        req(1'b0, 32'h3000_2000, 8'd0);
        wait_ar(1'b0);
        send_beats(1'b0, 1, -1, 32'hF000_0000, -1);
        @(negedge clock);
        chk("t5_err_overrun", 64'(protocol_err), 64'd1);
        chk("t5_still_busy", 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        send_beats(1'b0, 1, 0, 32'hF000_0001, -1);
        @(negedge clock);
        chk("t5_idle_after_rlast", 64'(busy), 64'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of an LSU burst.
        req(1'b1, 32'h6000_0000, 8'd3);
        wait_ar(1'b1);
        send_beats(1'b1, 1, -1, 32'h1234_0000, -1);
        io_master_rvalid = 1'b1; io_master_rlast = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_handshake", 64'({io_master_rready, lsu_rvalid, lsu_rlast, ifu_rvalid, ifu_rlast,
                                     io_master_arvalid}), 64'd0);
        chk("t6_rst_status", 64'({busy, grant_lsu, protocol_err}), 64'd0);
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // arlen=1 but rlast on beat 1; error is sticky across a later clean burst.
        req(1'b1, 32'h6000_0100, 8'd1);
        wait_ar(1'b1);
        send_beats(1'b1, 1, 0, 32'h2222_0000, -1);
        @(negedge clock);
        chk("t7_err_short", 64'(protocol_err), 64'd1);
        chk("t7_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        req(1'b0, 32'h3000_3000, 8'd0);
        wait_ar(1'b0);
        send_beats(1'b0, 1, 0, 32'h3333_0000, -1);
        @(negedge clock);
        chk("t7_err_sticky", 64'(protocol_err), 64'd1);

        chk("ar_queue_left", 64'(exp_ar.size()), 64'd0);
        chk("r_queue_left", 64'(exp_r.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
